// File: rtl/hazard_ctrl_pipe.sv
// Pipeline control registers (D->E->M->W) with load-use / RAW hazard detection and operand forwarding.
// Build option: define HAZARD_FORWARD_EN to enable forwarding; otherwise hazards are resolved by stalling.
module hazard_ctrl_pipe #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Regfile_weD,
    input  logic                   DataMem_weD,
    input  logic                   aluSrc1_muxD,
    input  logic                   aluSrc2_muxD,
    input  logic [3:0]             aluOpD,
    input  logic [1:0]             regSrc_muxD,
    input  logic [1:0]             regDst_muxD,
    input  logic [4:0]             rsD,
    input  logic [4:0]             rtD,
    input  logic [4:0]             rdD,
    input  logic                   flushD,
    output logic                   Regfile_weE,
    output logic                   DataMem_weE,
    output logic [3:0]             aluOpE,
    output logic                   aluSrc1_muxE,
    output logic                   aluSrc2_muxE,
    output logic [1:0]             regSrc_muxE,
    output logic [4:0]             rsE,
    output logic [4:0]             rtE,
    output logic [4:0]             writeRegE,
    output logic                   Regfile_weM,
    output logic                   DataMem_weM,
    output logic [1:0]             regSrc_muxM,
    output logic [4:0]             writeRegM,
    output logic                   Regfile_weW,
    output logic [1:0]             regSrc_muxW,
    output logic [4:0]             writeRegW,
    output logic                   stallF,
    output logic                   stallD,
    output logic [1:0]             forwardA,
    output logic [1:0]             forwardB,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [4:0] write_reg_d;
    logic       stall;
    logic       bubble_e;

    // True when a stage writing register dst feeds either D source; $0 never counts.
    function automatic logic reg_hit(input logic we, input logic [4:0] dst,
                                     input logic [4:0] src_a, input logic [4:0] src_b);
        return we && (dst != 5'd0) && ((dst == src_a) || (dst == src_b));
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        logic [STALL_CNT_W-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return (&v) ? v : v + one;
    endfunction

`ifdef HAZARD_FORWARD_EN
    // M is the younger producer, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic we_m, input logic [4:0] wr_m,
                                           input logic we_w, input logic [4:0] wr_w);
        if (we_m && (wr_m != 5'd0) && (wr_m == src))
            return 2'b10;
        else if (we_w && (wr_w != 5'd0) && (wr_w == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction
`endif

    always_comb begin
        write_reg_d = 5'd0;
        case (regDst_muxD)
            2'b01:   write_reg_d = rtD;
            2'b10:   write_reg_d = rdD;
            default: write_reg_d = 5'd0;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        forwardA = 2'b00;
        forwardB = 2'b00;
`ifdef HAZARD_FORWARD_EN
        stall    = reg_hit(Regfile_weE && (regSrc_muxE == 2'b10), writeRegE, rsD, rtD);
        forwardA = fwd_sel(rsE, Regfile_weM, writeRegM, Regfile_weW, writeRegW);
        forwardB = fwd_sel(rtE, Regfile_weM, writeRegM, Regfile_weW, writeRegW);
`else
        // Without forwarding, wait until the producer has reached W (write-before-read regfile).
        stall    = reg_hit(Regfile_weE, writeRegE, rsD, rtD) |
                   reg_hit(Regfile_weM, writeRegM, rsD, rtD);
`endif
    end

    assign stallF   = stall;
    assign stallD   = stall;
    assign bubble_e = stall | flushD;

    // D -> E boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Regfile_weE  <= 1'b0;
            DataMem_weE  <= 1'b0;
            aluOpE       <= 4'd0;
            aluSrc1_muxE <= 1'b0;
            aluSrc2_muxE <= 1'b0;
            regSrc_muxE  <= 2'b00;
            rsE          <= 5'd0;
            rtE          <= 5'd0;
            writeRegE    <= 5'd0;
        end else if (bubble_e) begin
            Regfile_weE  <= 1'b0;
            DataMem_weE  <= 1'b0;
            aluOpE       <= 4'd0;
            aluSrc1_muxE <= 1'b0;
            aluSrc2_muxE <= 1'b0;
            regSrc_muxE  <= 2'b00;
            rsE          <= 5'd0;
            rtE          <= 5'd0;
            writeRegE    <= 5'd0;
        end else begin
            Regfile_weE  <= Regfile_weD;
            DataMem_weE  <= DataMem_weD;
            aluOpE       <= aluOpD;
            aluSrc1_muxE <= aluSrc1_muxD;
            aluSrc2_muxE <= aluSrc2_muxD;
            regSrc_muxE  <= regSrc_muxD;
            rsE          <= rsD;
            rtE          <= rtD;
            writeRegE    <= write_reg_d;
        end
    end

    // E -> M boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Regfile_weM <= 1'b0;
            DataMem_weM <= 1'b0;
            regSrc_muxM <= 2'b00;
            writeRegM   <= 5'd0;
        end else begin
            Regfile_weM <= Regfile_weE;
            DataMem_weM <= DataMem_weE;
            regSrc_muxM <= regSrc_muxE;
            writeRegM   <= writeRegE;
        end
    end

    // M -> W boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Regfile_weW <= 1'b0;
            regSrc_muxW <= 2'b00;
            writeRegW   <= 5'd0;
        end else begin
            Regfile_weW <= Regfile_weM;
            regSrc_muxW <= regSrc_muxM;
            writeRegW   <= writeRegM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule
